// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, default
// multicycle latency and the bit positions inside the stage-valid vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int MUL_LAT_DEF = 3;

  // Stage positions inside vld_pipe; it shifts upward ID -> EX -> WB.
  localparam int S_ID = 0;
  localparam int S_EX = 1;
  localparam int S_WB = 2;

endpackage

// File: rtl/mul_stall_cnt.sv
// Multicycle stall counter: holds EX for exactly MUL_LAT stall cycles and then
// raises mdone for the single cycle in which EX is allowed to advance.
module mul_stall_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms,     // multicycle stall active this cycle
  output logic mdone
);

  localparam logic [2:0] LOAD = 3'(MUL_LAT - 1);

  logic [2:0] cnt;
  logic       busy;   // distinguishes the first stall cycle from a finished count

  // Load on the first stall cycle, count down, flag done on the last stall
  // cycle. Any cycle without a stall means EX advanced (or the op was
  // withdrawn), so everything clears and the next op starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      busy  <= 1'b0;
      mdone <= 1'b0;
    end else if (ms) begin
      if (!busy) begin
        if (LOAD == 3'd0) begin
          mdone <= 1'b1;
        end else begin
          cnt  <= LOAD;
          busy <= 1'b1;
        end
      end else if (cnt > 3'd1) begin
        cnt <= cnt - 3'd1;
      end else begin
        cnt   <= '0;
        busy  <= 1'b0;
        mdone <= 1'b1;
      end
    end else begin
      cnt   <= '0;
      busy  <= 1'b0;
      mdone <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Four-stage pipeline controller: run/drain/halt FSM, stage valid bits and
// hazard resolution (multicycle stall > branch flush > load-use stall).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic       CK,
  input  logic       RB,
  input  logic       START,
  input  logic       HALT_REQ,
  input  logic       ID_USES_RS,
  input  logic [2:0] ID_RS,
  input  logic       EX_LOAD,
  input  logic [2:0] EX_RD,
  input  logic       MUL_START,
  input  logic       BR_TAKEN,
  output logic       EN_IF,
  output logic       EN_ID,
  output logic       EN_EX,
  output logic       V_ID,
  output logic       V_EX,
  output logic       V_WB,
  output logic       STALL,
  output logic       FLUSH,
  output logic [1:0] STATE
);

  state_t     state_q, state_d;
  logic [2:0] vld_pipe;
  logic       mdone, ms, bf, lu, fv;

  // Hazard terms, each masked by its stage valid and by higher priorities.
  assign fv = (state_q == RUN);
  assign ms = vld_pipe[S_EX] & MUL_START & ~mdone;
  assign bf = vld_pipe[S_EX] & BR_TAKEN & ~ms;
  assign lu = vld_pipe[S_EX] & EX_LOAD & vld_pipe[S_ID] & ID_USES_RS &
              (ID_RS == EX_RD) & ~ms & ~bf;

  mul_stall_cnt #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk   (CK),
    .rst_n (RB),
    .ms    (ms),
    .mdone (mdone)
  );

  // FSM state register.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus stage enables and status flags.
  always_comb begin
    state_d = state_q;
    EN_EX   = ~ms;
    EN_ID   = ~ms & ~lu;
    EN_IF   = ~ms & ~lu & fv;
    STALL   = ms | lu;
    FLUSH   = bf;
    case (state_q)
      IDLE, HALTED: if (START) state_d = RUN;
      // A flush or stall in the same cycle keeps the halt from taking effect.
      RUN:          if (vld_pipe[S_ID] & HALT_REQ & ~ms & ~bf & ~lu) state_d = DRAIN;
      DRAIN:        if (vld_pipe == 3'b000) state_d = HALTED;
      default:      state_d = IDLE;
    endcase
  end

  // Stage valid bits: bubble into WB on a multicycle stall, kill ID/EX on a
  // taken branch, bubble into EX on load-use, otherwise shift.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      vld_pipe <= '0;
    end else if (ms) begin
      vld_pipe[S_WB] <= 1'b0;
    end else if (bf) begin
      vld_pipe <= 3'b100;
    end else if (lu) begin
      vld_pipe[S_EX] <= 1'b0;
      vld_pipe[S_WB] <= 1'b1;
    end else begin
      vld_pipe <= {vld_pipe[S_EX], vld_pipe[S_ID], fv};
    end
  end

  assign V_ID  = vld_pipe[S_ID];
  assign V_EX  = vld_pipe[S_EX];
  assign V_WB  = vld_pipe[S_WB];
  assign STATE = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, reset/stall corner sequences and
// a randomized run against a cycle-level reference model.
module tb_pipe_ctrl;

  localparam int LAT = 3;

  logic       CK = 1'b0, RB = 1'b0;
  logic       START = 1'b0, HALT_REQ = 1'b0, ID_USES_RS = 1'b0, EX_LOAD = 1'b0;
  logic       MUL_START = 1'b0, BR_TAKEN = 1'b0;
  logic [2:0] ID_RS = 3'd0, EX_RD = 3'd0;
  logic       EN_IF, EN_ID, EN_EX, V_ID, V_EX, V_WB, STALL, FLUSH;
  logic [1:0] STATE;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.MUL_LAT(LAT)) dut (
    .CK(CK), .RB(RB), .START(START), .HALT_REQ(HALT_REQ),
    .ID_USES_RS(ID_USES_RS), .ID_RS(ID_RS), .EX_LOAD(EX_LOAD), .EX_RD(EX_RD),
    .MUL_START(MUL_START), .BR_TAKEN(BR_TAKEN),
    .EN_IF(EN_IF), .EN_ID(EN_ID), .EN_EX(EN_EX),
    .V_ID(V_ID), .V_EX(V_EX), .V_WB(V_WB),
    .STALL(STALL), .FLUSH(FLUSH), .STATE(STATE)
  );

  always #5 CK = ~CK;

  // in = {START,HALT_REQ,ID_USES_RS,ID_RS,EX_LOAD,EX_RD,MUL_START,BR_TAKEN}
  // c  = {STALL,FLUSH,EN_IF,EN_ID,EN_EX}   (before the edge)
  // r  = {STATE,V_ID,V_EX,V_WB}            (after the edge)
  typedef struct {
    logic [11:0] in;
    logic [4:0]  c;
    logic [4:0]  r;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] comb_now();
    return {STALL, FLUSH, EN_IF, EN_ID, EN_EX};
  endfunction

  function automatic logic [4:0] regs_now();
    return {STATE, V_ID, V_EX, V_WB};
  endfunction

  task automatic drive(input logic [11:0] v);
    {START, HALT_REQ, ID_USES_RS, ID_RS, EX_LOAD, EX_RD, MUL_START, BR_TAKEN} = v;
  endtask

  // Reset from any state, check reset values, release, check first edge holds.
  task automatic do_reset();
    @(negedge CK);
    RB = 1'b0;
    drive(12'b0);
    #1;
    check("rst_regs", regs_now(), 5'b00000);
    check("rst_comb", comb_now(), 5'b00011);
    @(negedge CK);
    RB = 1'b1;
    @(posedge CK);
    #1;
    check("first_edge_hold", regs_now(), 5'b00000);
  endtask

  initial begin
    int n;
    int m_st, held;
    logic m_id, m_ex, m_wb, m_ms, m_bf, m_lu;
    logic [4:0] exp_c;

    tbl[0]  = '{12'b1_0_0_000_0_000_0_0, 5'b00011, 5'b01000}; // start
    tbl[1]  = '{12'b0_0_0_000_0_000_0_0, 5'b00111, 5'b01100};
    tbl[2]  = '{12'b0_0_0_000_0_000_0_0, 5'b00111, 5'b01110};
    tbl[3]  = '{12'b0_0_0_000_0_000_0_0, 5'b00111, 5'b01111};
    tbl[4]  = '{12'b0_0_1_101_1_101_0_0, 5'b10001, 5'b01101}; // load-use r5
    tbl[5]  = '{12'b0_0_1_101_1_101_0_0, 5'b00111, 5'b01110}; // EX bubble: no repeat
    tbl[6]  = '{12'b0_0_0_000_0_000_0_0, 5'b00111, 5'b01111};
    tbl[7]  = '{12'b0_0_0_000_0_000_1_0, 5'b10000, 5'b01110}; // mul stall 1
    tbl[8]  = '{12'b0_0_0_000_0_000_1_0, 5'b10000, 5'b01110}; // mul stall 2
    tbl[9]  = '{12'b0_0_0_000_0_000_1_0, 5'b10000, 5'b01110}; // mul stall 3
    tbl[10] = '{12'b0_0_0_000_0_000_1_0, 5'b00111, 5'b01111}; // EX advances
    tbl[11] = '{12'b0_0_0_000_0_000_0_0, 5'b00111, 5'b01111};
    tbl[12] = '{12'b0_1_1_011_1_011_0_1, 5'b01111, 5'b01001}; // br+halt+lu
    tbl[13] = '{12'b0_0_0_000_0_000_0_0, 5'b00111, 5'b01100};
    tbl[14] = '{12'b0_1_0_000_0_000_0_0, 5'b00111, 5'b10110}; // halt -> drain
    tbl[15] = '{12'b0_0_0_000_0_000_0_0, 5'b00011, 5'b10011};
    tbl[16] = '{12'b0_0_0_000_0_000_0_0, 5'b00011, 5'b10001};
    tbl[17] = '{12'b0_0_0_000_0_000_0_0, 5'b00011, 5'b10000};
    tbl[18] = '{12'b0_0_0_000_0_000_0_0, 5'b00011, 5'b11000}; // halted
    tbl[19] = '{12'b0_0_0_000_0_000_0_0, 5'b00011, 5'b11000};
    tbl[20] = '{12'b1_0_0_000_0_000_0_0, 5'b00011, 5'b01000}; // restart

    do_reset();

    for (int i = 0; i < 21; i++) begin
      @(negedge CK);
      drive(tbl[i].in);
      #1;
      check($sformatf("vec%0d_comb", i), comb_now(), tbl[i].c);
      @(posedge CK);
      #1;
      check($sformatf("vec%0d_regs", i), regs_now(), tbl[i].r);
    end

    // Fill the pipe, enter a multicycle stall, then reset in the middle of it.
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      drive(12'b0);
      @(posedge CK);
    end
    @(negedge CK);
    drive(12'b0_0_0_000_0_000_1_0);
    #1;
    check("pre_rst_stall", comb_now(), 5'b10000);
    @(negedge CK);
    #1;
    check("pre_rst_stall2", comb_now(), 5'b10000);
    RB = 1'b0;
    #1;
    check("midstall_rst_regs", regs_now(), 5'b00000);
    check("midstall_rst_comb", comb_now(), 5'b00011);
    @(negedge CK);
    drive(12'b0);
    RB = 1'b1;
    @(posedge CK);
    #1;
    check("post_rst_hold", regs_now(), 5'b00000);

    // Counter must start clean after the aborted stall: full LAT stall cycles.
    @(negedge CK);
    drive(12'b1_0_0_000_0_000_0_0);
    @(posedge CK);
    @(negedge CK);
    drive(12'b0);
    @(posedge CK);
    @(posedge CK);
    @(negedge CK);
    drive(12'b0_0_0_000_0_000_1_0);
    #1;
    n = 0;
    for (int k = 0; k < 10 && STALL; k++) begin
      n++;
      @(negedge CK);
      #1;
    end
    check("mul_stall_len", 5'(n), 5'(LAT));
    drive(12'b0);

    // Randomized run against the reference model.
    do_reset();
    m_st = 0; held = 0;
    m_id = 1'b0; m_ex = 1'b0; m_wb = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CK);
      START      = ($urandom_range(0, 7) == 0);
      HALT_REQ   = ($urandom_range(0, 15) == 0);
      ID_USES_RS = ($urandom_range(0, 1) == 0);
      ID_RS      = 3'($urandom_range(0, 3));
      EX_LOAD    = ($urandom_range(0, 2) == 0);
      EX_RD      = 3'($urandom_range(0, 3));
      MUL_START  = MUL_START ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
      BR_TAKEN   = ($urandom_range(0, 7) == 0);
      #1;
      // A multicycle op may occupy EX for LAT stalled cycles, then leaves.
      m_ms = m_ex && MUL_START && (held < LAT);
      m_bf = m_ex && BR_TAKEN && !m_ms;
      m_lu = m_ex && EX_LOAD && m_id && ID_USES_RS && (ID_RS == EX_RD) && !m_ms && !m_bf;
      exp_c = {m_ms || m_lu, m_bf, !m_ms && !m_lu && (m_st == 1), !m_ms && !m_lu, !m_ms};
      check("rand_comb", comb_now(), exp_c);

      case (m_st)
        0, 3: if (START) m_st = 1;
        1:    if (m_id && HALT_REQ && !m_ms && !m_bf && !m_lu) m_st = 2;
        2:    if (!m_id && !m_ex && !m_wb) m_st = 3;
        default: m_st = 0;
      endcase
      if (m_ms) begin
        m_wb = 1'b0;
        held++;
      end else begin
        held = 0;
        if (m_bf) begin
          m_id = 1'b0; m_ex = 1'b0; m_wb = 1'b1;
        end else if (m_lu) begin
          m_ex = 1'b0; m_wb = 1'b1;
        end else begin
          m_wb = m_ex;
          m_ex = m_id;
          // fetch uses the state before this edge
          m_id = (exp_c[2] || (exp_c[1:0] == 2'b11 && 1'b0)) ? 1'b1 : 1'b0;
        end
      end

      @(posedge CK);
      #1;
      check("rand_regs", regs_now(), {2'(m_st), m_id, m_ex, m_wb});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MUL_LAT, default 3, stall cycles a multicycle op holds EX (legal 1..7).
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-003 CK  in  1  clock, all state updates on rising edge.
REQ-004 RB  in  1  asynchronous active-low reset.
REQ-005 START  in  1  begin/resume fetch, sampled in IDLE or HALTED.
REQ-006 HALT_REQ  in  1  halt instruction decoded in ID.
REQ-007 ID_USES_RS  in  1  ID instruction reads a register; ID_RS  in  3  its source index.
REQ-008 EX_LOAD  in  1  EX instruction is a load; EX_RD  in  3  its destination index.
REQ-009 MUL_START  in  1  EX instruction is multicycle, held while it sits in EX.
REQ-010 BR_TAKEN  in  1  EX instruction is a taken branch.
REQ-011 EN_IF, EN_ID, EN_EX  out  1 each  load enables for IF/ID, ID/EX and EX/WB pipeline registers.
REQ-012 V_ID, V_EX, V_WB  out  1 each  stage valid bits (registered).
REQ-013 STALL, FLUSH  out  1 each  combinational status; STATE  out  2  FSM state.

Function
REQ-014 FSM states: IDLE=0, RUN=1, DRAIN=2, HALTED=3.
REQ-015 IDLE/HALTED + START -> RUN next cycle; otherwise hold.
REQ-016 Fetch valid FV = (STATE==RUN); V_ID <= FV when ID advances.
REQ-017 Multicycle stall MS: V_EX & MUL_START & ~MDONE; internal 3-bit counter loads MUL_LAT-1 on first MS cycle, decrements while nonzero, sets MDONE on reaching 0 with MS still counted that cycle; EX held exactly MUL_LAT cycles, advances next cycle; MDONE cleared when EX advances.
REQ-018 During MS: EN_IF=EN_ID=EN_EX=0 for front registers, V_WB <= 0 (bubble into WB), STALL=1.
REQ-019 Branch flush BF = V_EX & BR_TAKEN & ~MS: FLUSH=1, V_ID <= 0, V_EX <= 0, V_WB <= 1, all enables 1.
REQ-020 Load-use LU = V_EX & EX_LOAD & V_ID & ID_USES_RS & (ID_RS==EX_RD) & ~MS & ~BF: EN_IF=EN_ID=0, EN_EX=1, V_EX <= 0, V_WB <= 1, STALL=1, exactly one cycle.
REQ-021 Priority MS > BF > LU; no hazard: all enables 1, valids shift (V_WB<=V_EX, V_EX<=V_ID).
REQ-022 EN_IF additionally 0 when STATE != RUN.
REQ-023 RUN + V_ID & HALT_REQ & ~MS & ~BF & ~LU -> DRAIN; BF same cycle cancels halt.
REQ-024 DRAIN: FV=0, pipeline drains; when V_ID=V_EX=V_WB=0 -> HALTED.
REQ-025 Hazard inputs ignored when qualifying valid bit is 0.

Reset
REQ-026 RB low asynchronously: STATE=IDLE, V_ID=V_EX=V_WB=0, counter=0, MDONE=0; outputs EN_IF=0, STALL=FLUSH=0.
REQ-027 RB asserted mid-stall or mid-drain aborts the operation; no state survives.
REQ-028 First edge after RB release performs no state change unless START=1.

Structure
REQ-029 Shared package pipe_ctrl_pkg holds state encoding constants and MUL_LAT default.
REQ-030 One sub-module mul_stall_cnt (counter + MDONE), instantiated once.

Verification
REQ-031 START=1 one cycle, no hazards -> STATE=RUN next cycle, V_ID,V_EX,V_WB rise on cycles 2,3,4.
REQ-032 EX_LOAD=1,EX_RD=5, ID_USES_RS=1,ID_RS=5 -> STALL=1 one cycle, V_EX=0 bubble, EN_IF=EN_ID=0 that cycle.
REQ-033 MUL_START held, MUL_LAT=3 -> STALL=1 for 3 cycles, V_WB=0 during, EX advances cycle 4.
REQ-034 BR_TAKEN=1 with HALT_REQ=1 and LU true same cycle -> FLUSH=1, V_ID,V_EX cleared, STATE stays RUN.
REQ-035 HALT_REQ in RUN -> DRAIN, HALTED 2 cycles after V_WB last high; START -> RUN.
REQ-036 RB low mid-MUL stall -> all valids 0, STATE=IDLE immediately, STALL=0 without clock edge.
